// File: rtl/mmio_periph_hub.sv
// mmio_periph_hub: CPU-mapped hub for switches, debounced buttons with sticky events, LED/segment registers and LED blink.
module mmio_periph_hub #(
  parameter int NBTN       = 5,
  parameter int SW_W       = 24,
  parameter int LED_W      = 24,
  parameter int SEG_W      = 24,
  parameter int DEB_CYCLES = 200000,
  parameter int BLINK_INIT = 10000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        io_addr,
  input  logic              io_read,
  input  logic              io_write,
  input  logic [31:0]       io_wdata,
  output logic [31:0]       io_rdata,
  input  logic [SW_W-1:0]   switch_in,
  input  logic [NBTN-1:0]   button_in,
  output logic [LED_W-1:0]  led_out,
  output logic [SEG_W-1:0]  seg_data,
  output logic [NBTN-1:0]   btn_level
);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
  logic [SW_W-1:0] sw_s1, sw_s2;
  logic [NBTN-1:0] bt_s1, bt_s2, lvl_nxt, evt, evt_clr;
  logic [DW-1:0] cnt [NBTN];
  logic [LED_W-1:0] led, mask;
  logic [SEG_W-1:0] seg;
  logic [31:0] per, bcnt;
  logic phase;
  logic [2:0] a;
  logic unused_ok;
  assign a = io_addr[4:2];
  assign unused_ok = ^{io_addr[1:0], io_wdata};
  assign led_out = led & ~(mask & {LED_W{phase}});
  assign seg_data = seg;
  always_comb begin
    lvl_nxt = btn_level;
    for (int i = 0; i < NBTN; i++)
      lvl_nxt[i] = (bt_s2[i] != btn_level[i] && cnt[i] == DEB_MAX) ? bt_s2[i] : btn_level[i];
    evt_clr = ((io_read && a == 3'd2) ? evt : '0) | ((io_write && a == 3'd3) ? io_wdata[NBTN-1:0] : '0);
  end
  always_comb begin
    io_rdata = '0;
    case (a)
      3'd0: io_rdata[SW_W-1:0] = sw_s2;
      3'd1: io_rdata[NBTN-1:0] = btn_level;
      3'd2: io_rdata[NBTN-1:0] = evt;
      3'd4: io_rdata[LED_W-1:0] = led;
      3'd5: io_rdata[SEG_W-1:0] = seg;
      3'd6: io_rdata = per;
      3'd7: io_rdata[LED_W-1:0] = mask;
      default: io_rdata = '0;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      bt_s1 <= '0;
      bt_s2 <= '0;
      btn_level <= '0;
      evt <= '0;
      led <= '0;
      seg <= '0;
      mask <= '0;
      per <= 32'(BLINK_INIT);
      bcnt <= '0;
      phase <= 1'b0;
      for (int i = 0; i < NBTN; i++) cnt[i] <= '0;
    end else begin
      sw_s1 <= switch_in;
      sw_s2 <= sw_s1;
      bt_s1 <= button_in;
      bt_s2 <= bt_s1;
      btn_level <= lvl_nxt;
      for (int i = 0; i < NBTN; i++)
        cnt[i] <= (bt_s2[i] != btn_level[i] && cnt[i] != DEB_MAX) ? cnt[i] + DW'(1) : '0;
      // a new rising edge outranks a same-cycle clear
      evt <= (evt & ~evt_clr) | (lvl_nxt & ~btn_level);
      if (io_write && a == 3'd4) led <= io_wdata[LED_W-1:0];
      if (io_write && a == 3'd5) seg <= io_wdata[SEG_W-1:0];
      if (io_write && a == 3'd6) per <= io_wdata;
      if (io_write && a == 3'd7) mask <= io_wdata[LED_W-1:0];
      if ((io_write && a == 3'd6) || per == '0) begin
        bcnt <= '0;
        phase <= 1'b0;
      end else if (bcnt == per - 32'd1) begin
        bcnt <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_mmio_periph_hub.sv
// tb_mmio_periph_hub: random and directed stimulus checked every cycle against a behavioural model of the hub.
module tb_mmio_periph_hub;
  localparam int NBTN = 5, SW_W = 24, LED_W = 24, SEG_W = 24, DEB = 4, BINIT = 50;
  logic clock = 1'b0;
  logic reset;
  logic [4:0] io_addr;
  logic io_read, io_write;
  logic [31:0] io_wdata, io_rdata;
  logic [SW_W-1:0] switch_in;
  logic [NBTN-1:0] button_in, btn_level;
  logic [LED_W-1:0] led_out;
  logic [SEG_W-1:0] seg_data;
  int n_cmp = 0, n_bad = 0;
  mmio_periph_hub #(.NBTN(NBTN), .SW_W(SW_W), .LED_W(LED_W), .SEG_W(SEG_W),
                    .DEB_CYCLES(DEB), .BLINK_INIT(BINIT)) dut (
    .clock(clock), .reset(reset), .io_addr(io_addr), .io_read(io_read), .io_write(io_write),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .switch_in(switch_in), .button_in(button_in),
    .led_out(led_out), .seg_data(seg_data), .btn_level(btn_level));
  always #5 clock = ~clock;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: synchroniser history, run length of disagreeing samples, elapsed cycles since blink restart
  logic [31:0] m_sw [2];
  logic [31:0] m_bt [2];
  logic [31:0] lvl, evt, led, seg, per, mask;
  int run [NBTN];
  int unsigned t;
  function automatic logic [31:0] m_rd(input logic [4:0] ad);
    case (ad[4:2])
      3'd0: return m_sw[1];
      3'd1: return lvl;
      3'd2: return evt;
      3'd4: return led;
      3'd5: return seg;
      3'd6: return per;
      3'd7: return mask;
      default: return 32'd0;
    endcase
  endfunction
  function automatic logic m_phase();
    return per != 0 && ((t / per) % 2 == 1);
  endfunction
  always @(posedge clock) begin : model
    logic [31:0] nl, clr;
    if (reset) begin
      m_sw[0] = 0; m_sw[1] = 0; m_bt[0] = 0; m_bt[1] = 0;
      lvl = 0; evt = 0; led = 0; seg = 0; mask = 0; per = BINIT; t = 0;
      for (int i = 0; i < NBTN; i++) run[i] = 0;
    end else begin
      nl = lvl;
      for (int i = 0; i < NBTN; i++) begin
        if (m_bt[1][i] != lvl[i]) begin
          run[i]++;
          if (run[i] == DEB) begin
            nl[i] = m_bt[1][i];
            run[i] = 0;
          end
        end else run[i] = 0;
      end
      clr = (io_read && io_addr[4:2] == 3'd2) ? evt : 32'd0;
      if (io_write && io_addr[4:2] == 3'd3) clr |= io_wdata & 32'h1F;
      evt = ((evt & ~clr) | (nl & ~lvl)) & 32'h1F;
      lvl = nl;
      t = (io_write && io_addr[4:2] == 3'd6) ? 0 : t + 1;
      if (io_write) begin
        case (io_addr[4:2])
          3'd4: led = io_wdata & 32'hFFFFFF;
          3'd5: seg = io_wdata & 32'hFFFFFF;
          3'd6: per = io_wdata;
          3'd7: mask = io_wdata & 32'hFFFFFF;
          default: ;
        endcase
      end
      m_sw[1] = m_sw[0]; m_sw[0] = 32'(switch_in);
      m_bt[1] = m_bt[0]; m_bt[0] = 32'(button_in);
    end
  end
  always @(posedge clock) begin
    #1;
    chk("led_out", 32'(led_out), led & ~(m_phase() ? mask : 32'd0));
    chk("seg_data", 32'(seg_data), seg);
    chk("btn_level", 32'(btn_level), lvl);
    chk("io_rdata", io_rdata, m_rd(io_addr));
  end
  task automatic wr(input logic [4:0] ad, input logic [31:0] d);
    io_addr = ad; io_wdata = d; io_write = 1;
    @(negedge clock);
    io_write = 0;
  endtask
  task automatic rd_chk(input string nm, input logic [4:0] ad, input logic [31:0] exp);
    io_addr = ad; io_read = 1;
    #1 chk(nm, io_rdata, exp);
    @(negedge clock);
    io_read = 0;
  endtask
  initial begin
    reset = 1; io_addr = 0; io_read = 0; io_write = 0; io_wdata = 0; switch_in = 0; button_in = 0;
    repeat (3) @(negedge clock);
    reset = 0;
    @(negedge clock);
    chk("rst_led", 32'(led_out), 0);
    chk("rst_seg", 32'(seg_data), 0);
    chk("rst_btn", 32'(btn_level), 0);
    rd_chk("rst_blink_per", 5'h18, 32'd50);
    rd_chk("rst_evt", 5'h08, 0);
    for (int k = 0; k < 20; k++) begin
      button_in[2] = ((k >> 1) & 1) == 0;
      @(negedge clock);
    end
    button_in[2] = 1;
    repeat (5) @(negedge clock);
    chk("btn2_before", 32'(btn_level[2]), 0);
    @(negedge clock);
    chk("btn2_after6", 32'(btn_level[2]), 1);
    rd_chk("evt_first", 5'h08, 32'h04);
    rd_chk("evt_second", 5'h08, 32'h00);
    button_in[3] = 1;
    repeat (8) @(negedge clock);
    button_in[0] = 1;
    repeat (5) @(negedge clock);
    rd_chk("evt_race_old", 5'h08, 32'h08);
    rd_chk("evt_race_new", 5'h08, 32'h01);
    button_in[1] = 1;
    repeat (8) @(negedge clock);
    rd_chk("btn_reg", 5'h04, 32'h0F);
    wr(5'h0C, 32'h2);
    rd_chk("evt_w1c", 5'h08, 0);
    rd_chk("evtclr_rd", 5'h0C, 0);
    wr(5'h10, 32'h00FF0F);
    wr(5'h1C, 32'h0F);
    wr(5'h18, 32'd3);
    for (int k = 0; k < 12; k++) begin
      chk("blink", 32'(led_out), ((k / 3) % 2 == 1) ? 32'h00FF00 : 32'h00FF0F);
      @(negedge clock);
    end
    repeat (3) @(negedge clock);
    chk("blink_ph1", 32'(led_out), 32'h00FF00);
    wr(5'h18, 0);
    for (int k = 0; k < 4; k++) begin
      chk("blink_off", 32'(led_out), 32'h00FF0F);
      @(negedge clock);
    end
    switch_in = 24'hA5A5A5; io_addr = 5'h00;
    @(negedge clock);
    chk("sw_1cyc", io_rdata, 0);
    @(negedge clock);
    chk("sw_2cyc", io_rdata, 32'h00A5A5A5);
    wr(5'h14, 32'hFFFFFFFF);
    chk("seg_trunc", 32'(seg_data), 32'hFFFFFF);
    io_addr = 5'h10; io_read = 1; io_write = 1; io_wdata = 32'h123456;
    #1 chk("rdwr_old", io_rdata, 32'h00FF0F);
    @(negedge clock);
    io_read = 0; io_write = 0;
    chk("rdwr_new", 32'(led_out), 32'h123456);
    repeat (4000) begin
      reset = $urandom_range(0, 499) == 0;
      io_addr = 5'($urandom);
      io_read = $urandom_range(0, 2) == 0;
      io_write = $urandom_range(0, 2) == 0;
      io_wdata = (io_addr[4:2] == 3'd6) ? $urandom_range(0, 6) : $urandom;
      switch_in = SW_W'($urandom);
      for (int i = 0; i < NBTN; i++)
        if ($urandom_range(0, 5) == 0) button_in[i] = ~button_in[i];
      @(negedge clock);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
